// File: rtl/pam4_tx_symgen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pam4_tx_symgen : PAM4 transmit symbol generator (preamble + byte/PRBS7 payload)
// Optional: define PAM4_PRECODE_EN for 1/(1+D) mod-4 payload precoding. Rev 1.0
// ----------------------------------------------------------------------------
module pam4_tx_symgen #(
    parameter int         PREAMBLE_LEN = 32,
    parameter logic [6:0] PRBS_SEED    = 7'h5A,
    parameter int         FILL_LEVEL   = -1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [3:0] sym_out,
    output logic       sym_valid,
    output logic       preamble_active,
    output logic       frame_start,
    output logic       underrun
);

    localparam int         CNT_W    = (PREAMBLE_LEN > 2) ? $clog2(PREAMBLE_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [6:0] SEED     = (PRBS_SEED == 7'h00) ? 7'h7F : PRBS_SEED;
    localparam logic [3:0] FILL_SYM = 4'(FILL_LEVEL);
    localparam logic [3:0] LVL_P3   = 4'b0011;
    localparam logic [3:0] LVL_M3   = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2
    } state_t;

    state_t           state;
    logic             mode_q;
    logic [7:0]       buf_byte;
    logic [1:0]       buf_idx;
    logic             buf_full;
    logic [6:0]       lfsr;
    logic [CNT_W-1:0] pre_cnt;
    logic             first_sym;
    logic             accept;
    logic             prbs_b0;
    logic             prbs_b1;
    logic [1:0]       byte_pair;
    logic [1:0]       pay_bits;
    logic [1:0]       line_bits;

    function automatic logic [3:0] gray_level(input logic [1:0] b);
        logic [3:0] lvl;
        case (b)
            2'b00:   lvl = 4'b1101;
            2'b01:   lvl = 4'b1111;
            2'b11:   lvl = 4'b0001;
            default: lvl = 4'b0011;
        endcase
        return lvl;
    endfunction

    assign data_ready = (state == ST_PAYLOAD) && !mode_q && en && (!buf_full || buf_idx == 2'd3);
    assign accept     = data_valid && data_ready;

    // Two steps of x^7+x^6+1 per clock; lfsr[6] is the oldest bit.
    assign prbs_b0 = lfsr[6] ^ lfsr[5];
    assign prbs_b1 = lfsr[5] ^ lfsr[4];

    always_comb begin
        byte_pair = buf_byte[1:0];
        case (buf_idx)
            2'd0:    byte_pair = buf_byte[7:6];
            2'd1:    byte_pair = buf_byte[5:4];
            2'd2:    byte_pair = buf_byte[3:2];
            default: byte_pair = buf_byte[1:0];
        endcase
    end

    assign pay_bits = mode_q ? {prbs_b0, prbs_b1} : byte_pair;

`ifdef PAM4_PRECODE_EN
    logic [1:0] prec;
    assign line_bits = pay_bits - prec;
`else
    assign line_bits = pay_bits;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            mode_q          <= 1'b0;
            buf_byte        <= 8'h00;
            buf_idx         <= 2'd0;
            buf_full        <= 1'b0;
            lfsr            <= SEED;
            pre_cnt         <= '0;
            first_sym       <= 1'b0;
            sym_out         <= 4'd0;
            sym_valid       <= 1'b0;
            preamble_active <= 1'b0;
            frame_start     <= 1'b0;
            underrun        <= 1'b0;
`ifdef PAM4_PRECODE_EN
            prec            <= 2'd0;
`endif
        end else begin
            frame_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sym_valid       <= 1'b0;
                    sym_out         <= 4'd0;
                    preamble_active <= 1'b0;
                    if (en) begin
                        mode_q   <= mode;
                        underrun <= 1'b0;
                        lfsr     <= SEED;
                        pre_cnt  <= '0;
                        buf_full <= 1'b0;
                        state    <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (!en) begin
                        state           <= ST_IDLE;
                        sym_valid       <= 1'b0;
                        sym_out         <= 4'd0;
                        preamble_active <= 1'b0;
                    end else begin
                        sym_valid       <= 1'b1;
                        preamble_active <= 1'b1;
                        sym_out         <= pre_cnt[0] ? LVL_M3 : LVL_P3;
                        pre_cnt         <= pre_cnt + CNT_W'(1);
                        if (pre_cnt == CNT_LAST) begin
                            state     <= ST_PAYLOAD;
                            first_sym <= 1'b1;
`ifdef PAM4_PRECODE_EN
                            prec      <= 2'd0;
`endif
                        end
                    end
                end
                ST_PAYLOAD: begin
                    preamble_active <= 1'b0;
                    if ((mode_q && en) || (!mode_q && buf_full)) begin
                        sym_valid   <= 1'b1;
                        sym_out     <= gray_level(line_bits);
                        frame_start <= first_sym;
                        first_sym   <= 1'b0;
`ifdef PAM4_PRECODE_EN
                        prec        <= line_bits;
`endif
                        if (mode_q) begin
                            lfsr <= {lfsr[4:0], prbs_b0, prbs_b1};
                        end else begin
                            buf_idx <= buf_idx + 2'd1;
                            if (buf_idx == 2'd3) begin
                                buf_full <= 1'b0;
                                if (!en) state <= ST_IDLE;
                            end
                        end
                    end else if (en) begin
                        // Underrun slot: hold the line busy with the fill level.
                        sym_valid   <= 1'b1;
                        sym_out     <= FILL_SYM;
                        underrun    <= 1'b1;
                        frame_start <= first_sym;
                        first_sym   <= 1'b0;
                    end else begin
                        state     <= ST_IDLE;
                        sym_valid <= 1'b0;
                        sym_out   <= 4'd0;
                    end
                    if (accept) begin
                        buf_byte <= data_in;
                        buf_idx  <= 2'd0;
                        buf_full <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pam4_tx_symgen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pam4_tx_symgen : randomized scoreboard bench for pam4_tx_symgen. Rev 1.0
// ----------------------------------------------------------------------------
module tb_pam4_tx_symgen;

    localparam int         PLEN = 32;
    localparam logic [6:0] SEED = 7'h5A;
    localparam int         FILL = -1;

    logic       clk = 1'b0;
    logic       rst, en, mode, data_valid;
    logic [7:0] data_in;
    logic       data_ready, sym_valid, preamble_active, frame_start, underrun;
    logic [3:0] sym_out;

    always #5 clk = ~clk;

    pam4_tx_symgen #(.PREAMBLE_LEN(PLEN), .PRBS_SEED(SEED), .FILL_LEVEL(FILL)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .sym_out(sym_out),
        .sym_valid(sym_valid), .preamble_active(preamble_active),
        .frame_start(frame_start), .underrun(underrun)
    );

    typedef struct {
        bit v;
        int lvl;
        bit pre;
        bit fs;
        bit und;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: 0 idle, 1 preamble, 2 payload
    int       mst = 0;
    int       pc = 0;
    bit       mmode = 0;
    bit       mund = 0;
    bit       mfirst = 0;
    bit [1:0] pend[$];
    bit       hist[$];
    bit [1:0] p = 0;
    logic [6:0] seed_eff;

    function automatic int gray_lvl(input bit [1:0] b);
        case (b)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    // PRBS7 as the recurrence b[n] = b[n-7] ^ b[n-6].
    task automatic next_bit(output bit b);
        b = hist[0] ^ hist[1];
        hist.push_back(b);
        void'(hist.pop_front());
    endtask

    task automatic pay_level(input bit [1:0] d, output int lvl);
`ifdef PAM4_PRECODE_EN
        p   = d - p;
        lvl = gray_lvl(p);
`else
        lvl = gray_lvl(d);
`endif
    endtask

    task automatic model_reset();
        mst = 0; mund = 0; mfirst = 0; p = 0;
        pend.delete();
    endtask

    function automatic exp_t idle_entry();
        exp_t x;
        x.v = 0; x.lvl = 0; x.pre = 0; x.fs = 0; x.und = 0;
        return x;
    endfunction

    // One clock: drive inputs, check data_ready, predict the next edge's outputs.
    task automatic cyc(input bit e, input bit m, input bit dv, input bit [7:0] din, output bit acc);
        exp_t     x;
        bit       rdy;
        bit [1:0] d;
        bit       b;
        @(posedge clk);
        #2;
        en = e; mode = m; data_valid = dv; data_in = din;
        x = idle_entry();
        rdy = (mst == 2) && !mmode && e && (pend.size() <= 1);
        #1;
        total++;
        if (data_ready !== rdy) begin
            bad++;
            $display("FAIL data_ready t=%0t got=%b want=%b", $time, data_ready, rdy);
        end
        acc = rdy && dv;
        case (mst)
            0: if (e) begin
                mmode = m; mund = 0; mst = 1; pc = 0; mfirst = 1;
                pend.delete();
                hist.delete();
                for (int i = 6; i >= 0; i--) hist.push_back(seed_eff[i]);
            end
            1: if (!e) mst = 0;
               else begin
                   x.v = 1; x.pre = 1; x.lvl = (pc % 2 == 0) ? 3 : -3;
                   pc++;
                   if (pc == PLEN) begin mst = 2; p = 0; end
               end
            default: begin
                if (mmode) begin
                    if (!e) mst = 0;
                    else begin
                        next_bit(b); d[1] = b;
                        next_bit(b); d[0] = b;
                        x.v = 1; pay_level(d, x.lvl); x.fs = mfirst; mfirst = 0;
                    end
                end else if (pend.size() > 0) begin
                    d = pend.pop_front();
                    x.v = 1; pay_level(d, x.lvl); x.fs = mfirst; mfirst = 0;
                    if (pend.size() == 0 && !e) mst = 0;
                end else if (e) begin
                    x.v = 1; x.lvl = FILL; mund = 1; x.fs = mfirst; mfirst = 0;
                end else begin
                    mst = 0;
                end
            end
        endcase
        if (acc) begin
            pend.push_back(din[7:6]); pend.push_back(din[5:4]);
            pend.push_back(din[3:2]); pend.push_back(din[1:0]);
        end
        x.und = mund;
        exp_q.push_back(x);
    endtask

    // Monitor: pops one expected entry per clock and compares all outputs.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            total++;
            if (sym_valid !== x.v || $signed(sym_out) != x.lvl || preamble_active !== x.pre ||
                frame_start !== x.fs || underrun !== x.und) begin
                bad++;
                $display("FAIL symbol t=%0t got v=%b lvl=%0d pre=%b fs=%b und=%b want v=%b lvl=%0d pre=%b fs=%b und=%b",
                         $time, sym_valid, $signed(sym_out), preamble_active, frame_start, underrun,
                         x.v, x.lvl, x.pre, x.fs, x.und);
            end
        end
    end

    task automatic check_reset_state(input string name);
        total++;
        if (sym_valid !== 1'b0 || sym_out !== 4'd0 || underrun !== 1'b0 || data_ready !== 1'b0 ||
            preamble_active !== 1'b0 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL %s got v=%b sym=%h und=%b rdy=%b pre=%b fs=%b want all zero",
                     name, sym_valid, sym_out, underrun, data_ready, preamble_active, frame_start);
        end
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(0, $urandom_range(0, 1), 0, 8'h00, acc);
    endtask

    initial begin
        bit       acc;
        bit [7:0] bytes [2];
        int       idx;
        seed_eff = (SEED == 7'h00) ? 7'h7F : SEED;
        bytes[0] = 8'hB4; bytes[1] = 8'h1E;
        rst = 1; en = 0; mode = 0; data_valid = 0; data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_state");
        @(posedge clk);
        #2;
        rst = 0;
        model_reset();
        idle_cycles(3);

        // Burst 1: byte mode, directed bytes, underrun gap, random traffic, mode toggles
        idx = 0;
        for (int c = 0; c < 1 + PLEN + 14; c++) begin
            cyc(1, (c == 0) ? 1'b0 : 1'($urandom_range(0, 1)), idx < 2, bytes[idx < 2 ? idx : 1], acc);
            if (acc) idx++;
        end
        for (int c = 0; c < 6; c++) cyc(1, 1, 0, 8'h00, acc);
        for (int c = 0; c < 60; c++)
            cyc(1, $urandom_range(0, 1), $urandom_range(0, 3) != 0, 8'($urandom), acc);
        for (int c = 0; c < 6; c++) cyc(0, 0, 1, 8'($urandom), acc);
        idle_cycles(3);

        // Burst 2: PRBS7 payload longer than one period, mode toggled throughout
        for (int c = 0; c < 1 + PLEN + 300; c++)
            cyc(1, (c == 0) ? 1'b1 : 1'($urandom_range(0, 1)), $urandom_range(0, 1), 8'($urandom), acc);
        idle_cycles(4);

        // Burst 3: byte mode, en dropped mid-byte with two symbols still pending
        for (int c = 0; c < 400; c++) begin
            cyc(1, (c == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1, 8'($urandom), acc);
            if (c > PLEN + 10 && pend.size() == 2) break;
        end
        for (int c = 0; c < 6; c++) cyc(0, 0, 1, 8'($urandom), acc);
        idle_cycles(2);

        // Burst 4: aborted during preamble
        for (int c = 0; c < 10; c++) cyc(1, 0, 0, 8'h00, acc);
        idle_cycles(3);

        // Burst 5: reset asserted mid-payload, released with en low
        for (int c = 0; c < 1 + PLEN + 7; c++)
            cyc(1, (c == 0) ? 1'b0 : 1'($urandom_range(0, 1)), (c % 3) != 0, 8'($urandom), acc);
        @(posedge clk);
        #2;
        rst = 1; en = 0; data_valid = 0;
        #1;
        check_reset_state("reset_mid_payload");
        model_reset();
        exp_q.push_back(idle_entry());
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #2;
            exp_q.push_back(idle_entry());
        end
        @(posedge clk);
        #2;
        rst = 0;
        idle_cycles(6);

        // Burst 6: fresh byte burst after reset
        for (int c = 0; c < 1 + PLEN + 30; c++)
            cyc(1, (c == 0) ? 1'b0 : 1'($urandom_range(0, 1)), $urandom_range(0, 1), 8'($urandom), acc);
        for (int c = 0; c < 6; c++) cyc(0, 0, 0, 8'h00, acc);
        idle_cycles(2);

        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
